// File: rtl/hash_generator_if.sv
// Request/response bundle between a keystream consumer and hash_generator.
//   request_byte_pulse       one-cycle request for one hash byte
//   key_byte_in              key byte, qualified by key_byte_pulse
//   key_byte_pulse           one-cycle strobe for key_byte_in
//   hash_byte                last generated byte, stable between completions
//   hash_byte_pulse          one-cycle strobe marking a new hash_byte
//   hash_generator_state_out current generator state (GROUND/SEEDING/READY/GENERATING)
// The master is the requester; the slave is the generator.
interface hash_generator_if;
    typedef logic [1:0] hash_generator_state_t;

    logic                  request_byte_pulse;
    logic [7:0]            key_byte_in;
    logic                  key_byte_pulse;
    logic [7:0]            hash_byte;
    logic                  hash_byte_pulse;
    hash_generator_state_t hash_generator_state_out;

    modport master (
        output request_byte_pulse, key_byte_in, key_byte_pulse,
        input  hash_byte, hash_byte_pulse, hash_generator_state_out
    );

    modport slave (
        input  request_byte_pulse, key_byte_in, key_byte_pulse,
        output hash_byte, hash_byte_pulse, hash_generator_state_out
    );
endinterface

// File: rtl/hash_generator.sv
// Keystream byte source built on a 32-bit Galois LFSR.
// The LFSR starts from SEED after reset, or from a 4-byte key loaded through
// key_byte_in/key_byte_pulse (first byte lands in bits [7:0]). Each request
// clocks the LFSR 8 times, assembling the output bits LSB first, then presents
// the byte on hash_byte with a one-cycle hash_byte_pulse.
// Ports:
//   clk   system clock
//   nrst  asynchronous active-low reset
//   bus   hash_generator_if.slave (request, key load, hash byte, state)
// State encoding: GROUND=0, SEEDING=1, READY=2, GENERATING=3.
module hash_generator #(
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter logic [31:0] TAPS      = 32'h8020_0003,
    parameter int          KEY_BYTES = 4
) (
    input  logic             clk,
    input  logic             nrst,
    hash_generator_if.slave  bus
);
    localparam logic [1:0] GROUND     = 2'd0;
    localparam logic [1:0] SEEDING    = 2'd1;
    localparam logic [1:0] READY      = 2'd2;
    localparam logic [1:0] GENERATING = 2'd3;

    // Index of the key byte that completes a load.
    localparam logic [1:0] LAST_KEY_IDX = 2'(KEY_BYTES - 1);

    logic [1:0]  state_reg;
    logic [31:0] lfsr_reg;
    logic [31:0] key_sr_reg;
    logic [1:0]  key_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic        seeded_reg;
    logic [7:0]  acc_reg;
    logic [7:0]  hash_byte_reg;
    logic        hash_pulse_reg;

    logic        lfsr_out;
    logic [31:0] lfsr_next;
    logic [31:0] key_next;
    logic [7:0]  acc_next;

    assign lfsr_out = lfsr_reg[0];

    // Galois step: shift right, fold the taps in when the bit leaving is 1.
    for (genvar gi = 0; gi < 31; gi++) begin : g_lfsr
        assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (lfsr_out & TAPS[gi]);
    end
    assign lfsr_next[31] = lfsr_out & TAPS[31];

    // New key bytes enter at the top so the first byte ends up in [7:0].
    assign key_next = {bus.key_byte_in, key_sr_reg[31:8]};

    // Bits enter at the top; after 8 shifts the first step's bit is bit 0.
    assign acc_next = {lfsr_out, acc_reg[7:1]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg      <= GROUND;
            lfsr_reg       <= SEED;
            key_sr_reg     <= '0;
            key_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            seeded_reg     <= 1'b0;
            acc_reg        <= '0;
            hash_byte_reg  <= 8'h00;
            hash_pulse_reg <= 1'b0;
        end else begin
            hash_pulse_reg <= 1'b0;
            case (state_reg)
                GROUND, READY: begin
                    // A key byte takes priority over a coincident request.
                    if (bus.key_byte_pulse) begin
                        key_sr_reg  <= key_next;
                        key_cnt_reg <= 2'd1;
                        state_reg   <= SEEDING;
                    end else if (bus.request_byte_pulse) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= GENERATING;
                    end
                end
                SEEDING: begin
                    // The LFSR keeps running value until the full key commits.
                    if (bus.key_byte_pulse) begin
                        key_sr_reg <= key_next;
                        if (key_cnt_reg == LAST_KEY_IDX) begin
                            // An all-zero LFSR would lock up, so fall back to SEED.
                            lfsr_reg    <= (key_next == 32'd0) ? SEED : key_next;
                            seeded_reg  <= 1'b1;
                            key_cnt_reg <= '0;
                            state_reg   <= READY;
                        end else begin
                            key_cnt_reg <= key_cnt_reg + 2'd1;
                        end
                    end
                end
                GENERATING: begin
                    lfsr_reg    <= lfsr_next;
                    acc_reg     <= acc_next;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        hash_byte_reg  <= acc_next;
                        hash_pulse_reg <= 1'b1;
                        state_reg      <= seeded_reg ? READY : GROUND;
                    end
                end
                default: state_reg <= GROUND;
            endcase
        end
    end

    assign bus.hash_byte                = hash_byte_reg;
    assign bus.hash_byte_pulse          = hash_pulse_reg;
    assign bus.hash_generator_state_out = state_reg;
endmodule
